// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS lane receiver: control-token word alignment and 10b->8b decode.
module tmds_channel_decoder #(
    parameter int CTRL_RUN   = 8,
    parameter int SEARCH_WIN = 2048,
    parameter int LOSS_WIN   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raw_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset,
    output logic       slip,
    output logic [7:0] loss_cnt
);
    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int WIN_W  = $clog2(SEARCH_WIN);
    localparam int LOSS_W = $clog2(LOSS_WIN);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state, state_next;

    logic [9:0]        raw_prev;
    logic [9:0]        sym_q;
    logic [19:0]       win;
    logic [19:0]       win_shift;
    logic [RUN_W-1:0]  run_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [LOSS_W-1:0] loss_timer;
    logic              is_token;
    logic [1:0]        token_val;
    logic              run_hit;
    logic              win_done;
    logic              loss_done;
    logic              do_slip;
    logic              do_drop;
    logic [7:0]        q;
    logic [7:0]        dec;

    // Bit 0 of the window is the earliest serial bit, so offset 0 is raw_prev.
    assign win       = {raw_in, raw_prev};
    assign win_shift = win >> offset;

    always_comb begin
        is_token  = 1'b1;
        token_val = 2'b00;
        case (sym_q)
            10'h354: token_val = 2'b00;
            10'h0AB: token_val = 2'b01;
            10'h154: token_val = 2'b10;
            10'h2AB: token_val = 2'b11;
            default: is_token  = 1'b0;
        endcase
    end

    always_comb begin
        q      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = 8'h00;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Only the token that completes a run of exactly CTRL_RUN counts as a hit.
    assign run_hit   = is_token && (run_cnt == RUN_W'(CTRL_RUN - 1));
    assign win_done  = (win_cnt == WIN_W'(SEARCH_WIN - 1));
    assign loss_done = (loss_timer == LOSS_W'(LOSS_WIN - 1));
    assign locked    = (state == LOCKED);

    always_comb begin
        state_next = state;
        do_slip    = 1'b0;
        do_drop    = 1'b0;
        case (state)
            SEARCH: begin
                if (run_hit) begin
                    state_next = LOCKED;
                end else if (win_done) begin
                    do_slip = 1'b1;
                end
            end
            LOCKED: begin
                if (loss_done && !run_hit) begin
                    state_next = SEARCH;
                    do_drop    = 1'b1;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_prev   <= 10'h000;
            sym_q      <= 10'h000;
            run_cnt    <= '0;
            win_cnt    <= '0;
            loss_timer <= '0;
            offset     <= 4'd0;
            slip       <= 1'b0;
            loss_cnt   <= 8'd0;
            data       <= 8'h00;
            ctrl       <= 2'b00;
            de         <= 1'b0;
        end else begin
            raw_prev <= raw_in;
            sym_q    <= win_shift[9:0];
            slip     <= do_slip;

            if (do_slip || do_drop || !is_token) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_W'(CTRL_RUN)) begin
                run_cnt <= run_cnt + 1'b1;
            end

            if (state == SEARCH && !run_hit && !do_slip) begin
                win_cnt <= win_cnt + 1'b1;
            end else begin
                win_cnt <= '0;
            end

            if (state == LOCKED && !run_hit && !do_drop) begin
                loss_timer <= loss_timer + 1'b1;
            end else begin
                loss_timer <= '0;
            end

            if (do_slip) begin
                offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            end

            if (do_drop && loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end

            // Outputs stay quiet until alignment is trusted.
            if (state != LOCKED) begin
                data <= 8'h00;
                ctrl <= 2'b00;
                de   <= 1'b0;
            end else if (is_token) begin
                data <= 8'h00;
                ctrl <= token_val;
                de   <= 1'b0;
            end else begin
                data <= dec;
                de   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - scoreboard bench for tmds_channel_decoder.
module tb_tmds_channel_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] raw_in = 10'h000;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;
    logic       slip;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int e = 0;
    bit sb_en = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] c;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   slip_q[$];

    tmds_channel_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (raw_in),
        .data     (data),
        .ctrl     (ctrl),
        .de       (de),
        .locked   (locked),
        .offset   (offset),
        .slip     (slip),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    // e is the index of the next active edge; edge 0 is the first one with reset low.
    always @(posedge clk) e <= reset ? 0 : e + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
        logic [19:0] d;
        d = {v, v} << n;
        return d[19:10];
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (slip) begin
            if (slip_q.size() == 0) check("unexpected_slip_edge", e - 1, -1);
            else check("slip_edge", e - 1, slip_q.pop_front());
        end
        if (sb_en && de) begin
            if (exp_q.size() == 0) begin
                check("unexpected_de_edge", e - 1, -1);
            end else begin
                x = exp_q.pop_front();
                check("dec_data", data, x.d);
                check("dec_ctrl", ctrl, x.c);
                check("dec_edge", e - 1, x.at);
            end
        end
    end

    task automatic send(input logic [9:0] w, input int n);
        repeat (n) begin
            raw_in = w;
            @(negedge clk);
        end
    endtask

    task automatic send_data(input logic [9:0] w, input logic [7:0] d, input logic [1:0] c);
        exp_t x;
        x.d = d;
        x.c = c;
        x.at = e + 2;
        exp_q.push_back(x);
        raw_in = w;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n, input logic [9:0] w);
        reset = 1'b1;
        raw_in = 10'h000;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        raw_in = w;
    endtask

    task automatic wait_lock(input logic want, input int bound, output int at);
        int n;
        n = 0;
        while (locked !== want && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (locked !== want) begin
            check("lock_wait_timeout", locked, want);
            at = -1;
        end else begin
            at = e - 1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_offset"}, offset, 0);
        check({tag, "_loss_cnt"}, loss_cnt, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_ctrl"}, ctrl, 0);
        check({tag, "_slip"}, slip, 0);
    endtask

    initial begin
        int s;
        int t;
        int at;

        repeat (3) @(negedge clk);
        check_quiet("reset");

        // Seven tokens between data symbols must not lock.
        reset = 1'b0;
        send(10'h100, 2);
        send(10'h354, 7);
        send(10'h100, 10);
        check("short_run_search_locked", locked, 0);

        // Aligned lock on continuous 0x354.
        apply_reset(1, 10'h354);
        wait_lock(1'b1, 40, at);
        check("offset0_lock_edge", at, 9);
        check("offset0_offset", offset, 0);
        @(negedge clk);
        check("offset0_ctrl", ctrl, 0);
        check("offset0_de", de, 0);

        // Data decode; ctrl carries the preceding 0x2AB token.
        send(10'h2AB, 3);
        sb_en = 1'b1;
        send_data(10'h100, 8'h00, 2'b11);
        send_data(10'h1FF, 8'h01, 2'b11);
        send_data(10'h2FF, 8'hFE, 2'b11);
        send(10'h354, 4);
        check("data_queue_drained", exp_q.size(), 0);
        sb_en = 1'b0;

        // One full run, then data with a short run inside; loss timed from the hit.
        send(10'h100, 2);
        s = e;
        send(10'h354, 8);
        send(10'h100, 1000);
        send(10'h354, 7);
        raw_in = 10'h100;
        wait_lock(1'b0, 5000, at);
        check("loss_edge", at, s + 4105);
        check("loss_cnt_after_loss", loss_cnt, 1);
        check("offset_after_loss", offset, 0);
        @(negedge clk);
        check("unlocked_de", de, 0);
        check("unlocked_data", data, 0);
        check("unlocked_ctrl", ctrl, 0);

        t = e;
        raw_in = 10'h354;
        wait_lock(1'b1, 100, at);
        check("relock_edge", at, t + 9);
        check("relock_offset", offset, 0);
        check("relock_loss_cnt", loss_cnt, 1);

        // 0x0AB stream delayed by three bits.
        apply_reset(2, rotl(10'h0AB, 3));
        slip_q.push_back(2047);
        slip_q.push_back(4095);
        slip_q.push_back(6143);
        wait_lock(1'b1, 7000, at);
        check("off3_lock_edge", at, 6152);
        check("off3_offset", offset, 3);
        repeat (2) @(negedge clk);
        check("off3_ctrl", ctrl, 1);
        check("off3_de", de, 0);
        check("off3_slips_seen", slip_q.size(), 0);

        // Offset 5: lock, lose, relock in place, then reset mid-lock.
        apply_reset(2, rotl(10'h2AB, 5));
        for (int i = 1; i <= 5; i++) slip_q.push_back(2048 * i - 1);
        wait_lock(1'b1, 11000, at);
        check("off5_lock_edge", at, 10248);
        check("off5_offset", offset, 5);
        repeat (2) @(negedge clk);
        check("off5_ctrl", ctrl, 3);
        raw_in = rotl(10'h100, 5);
        wait_lock(1'b0, 5000, at);
        check("off5_loss_cnt", loss_cnt, 1);
        check("off5_offset_kept", offset, 5);
        raw_in = rotl(10'h2AB, 5);
        wait_lock(1'b1, 100, at);
        check("off5_relock_offset", offset, 5);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_quiet("midlock_reset");

        check("slip_queue_drained", slip_q.size(), 0);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
